// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types and constants for the DDR burst arbiter: FSM states,
// source indices for the four burst channels and default bus widths.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int SRC_P0_WR = 0;
    localparam int SRC_P0_RD = 1;
    localparam int SRC_P1_WR = 2;
    localparam int SRC_P1_RD = 3;

    localparam int DEF_AW = 25;
    localparam int DEF_DW = 32;
    localparam int DEF_LW = 10;

    // Source index to one-hot grant vector.
    function automatic logic [3:0] src_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// Burst port between the arbiter and ddr_ctrl. The arbiter drives the
// request side (master); ddr_ctrl answers with the data/finish strobes.
interface ddr_burst_arbiter_if
    import ddr_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
);
    logic          wr_burst_req;
    logic [AW-1:0] wr_burst_addr;
    logic [LW-1:0] wr_burst_len;
    logic [DW-1:0] wr_burst_data;
    logic          wr_burst_data_req;
    logic          wr_burst_finish;

    logic          rd_burst_req;
    logic [AW-1:0] rd_burst_addr;
    logic [LW-1:0] rd_burst_len;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_data_valid;
    logic          rd_burst_finish;

    modport master (
        output wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
        input  wr_burst_data_req, wr_burst_finish,
        output rd_burst_req, rd_burst_addr, rd_burst_len,
        input  rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
        output wr_burst_data_req, wr_burst_finish,
        input  rd_burst_req, rd_burst_addr, rd_burst_len,
        output rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );

endinterface

// File: rtl/ddr_burst_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: the first requesting index at
// or after ptr (wrapping) wins.
module ddr_arb_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the nearest requester is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Shares the single ddr_ctrl burst port between two clients, each with a
// write and a read channel. One burst is granted at a time by round-robin;
// address/length are latched at grant and strobes are routed only to the
// granted client while the burst is outstanding.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst; pick a winner when init is done and any req is set
// GRANT | winner latched, timeout counter running, ddr req next cycle
// WAIT  | ddr req held; forward strobes; end on finish or timeout
// DONE  | one-cycle gap with req dropped and grant cleared
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int LW      = DEF_LW,
    parameter int TIMEOUT = 4096
) (
    input  logic          phy_clk,
    input  logic          rst_n,
    input  logic          ddr_init_done,

    input  logic          p0_wr_req,
    input  logic [AW-1:0] p0_wr_addr,
    input  logic [LW-1:0] p0_wr_len,
    input  logic [DW-1:0] p0_wr_data,
    output logic          p0_wr_data_req,
    output logic          p0_wr_finish,
    input  logic          p0_rd_req,
    input  logic [AW-1:0] p0_rd_addr,
    input  logic [LW-1:0] p0_rd_len,
    output logic          p0_rd_data_valid,
    output logic          p0_rd_finish,

    input  logic          p1_wr_req,
    input  logic [AW-1:0] p1_wr_addr,
    input  logic [LW-1:0] p1_wr_len,
    input  logic [DW-1:0] p1_wr_data,
    output logic          p1_wr_data_req,
    output logic          p1_wr_finish,
    input  logic          p1_rd_req,
    input  logic [AW-1:0] p1_rd_addr,
    input  logic [LW-1:0] p1_rd_len,
    output logic          p1_rd_data_valid,
    output logic          p1_rd_finish,

    output logic [DW-1:0] rd_data_out,

    ddr_burst_arbiter_if.master ddr,

    output logic [3:0]    grant,
    output logic          arb_busy,
    output logic          arb_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [1:0]    ptr;
    logic [3:0]    grant_q;
    logic [CW-1:0] tmo_cnt;
    logic          timeout_q;
    logic [AW-1:0] wr_addr_q;
    logic [AW-1:0] rd_addr_q;
    logic [LW-1:0] wr_len_q;
    logic [LW-1:0] rd_len_q;

    logic [3:0]    req_vec;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          start_grant;
    logic          abort;
    logic          in_wait;
    logic          wr_gnt;
    logic          rd_gnt;
    logic          fin_match;
    logic          tmo_hit;

    assign req_vec = {p1_rd_req, p1_wr_req, p0_rd_req, p0_wr_req};

    ddr_arb_rr_pick u_pick (
        .req   (req_vec),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign in_wait   = (state == WAIT);
    assign wr_gnt    = grant_q[SRC_P0_WR] | grant_q[SRC_P1_WR];
    assign rd_gnt    = grant_q[SRC_P0_RD] | grant_q[SRC_P1_RD];
    assign fin_match = in_wait & ((wr_gnt & ddr.wr_burst_finish) |
                                  (rd_gnt & ddr.rd_burst_finish));
    assign tmo_hit   = in_wait & (tmo_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge phy_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a real finish wins over a coincident timeout.
    always_comb begin
        state_nxt   = state;
        start_grant = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (ddr_init_done && pick_valid) begin
                    state_nxt   = GRANT;
                    start_grant = 1'b1;
                end
            end
            GRANT: state_nxt = WAIT;
            WAIT: begin
                if (fin_match) begin
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    abort     = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, latched burst parameters and timeout counter.
    always_ff @(posedge phy_clk) begin
        if (!rst_n) begin
            grant_q   <= '0;
            ptr       <= '0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_len_q  <= '0;
            rd_len_q  <= '0;
        end else begin
            timeout_q <= abort;
            if (start_grant) begin
                grant_q <= src_onehot(pick_idx);
                ptr     <= pick_idx + 2'd1;
                tmo_cnt <= '0;
                if (!pick_idx[0]) begin
                    wr_addr_q <= pick_idx[1] ? p1_wr_addr : p0_wr_addr;
                    wr_len_q  <= pick_idx[1] ? p1_wr_len  : p0_wr_len;
                end else begin
                    rd_addr_q <= pick_idx[1] ? p1_rd_addr : p0_rd_addr;
                    rd_len_q  <= pick_idx[1] ? p1_rd_len  : p0_rd_len;
                end
            end
            if ((state == GRANT || state == WAIT) && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (in_wait && state_nxt == DONE) begin
                grant_q <= '0;
            end
        end
    end

    // Outputs toward ddr_ctrl and status.
    always_comb begin
        ddr.wr_burst_req  = in_wait & wr_gnt;
        ddr.rd_burst_req  = in_wait & rd_gnt;
        ddr.wr_burst_addr = wr_addr_q;
        ddr.wr_burst_len  = wr_len_q;
        ddr.rd_burst_addr = rd_addr_q;
        ddr.rd_burst_len  = rd_len_q;
        ddr.wr_burst_data = '0;
        if (grant_q[SRC_P0_WR]) begin
            ddr.wr_burst_data = p0_wr_data;
        end else if (grant_q[SRC_P1_WR]) begin
            ddr.wr_burst_data = p1_wr_data;
        end
        grant       = grant_q;
        arb_busy    = (state == GRANT) || (state == WAIT);
        arb_timeout = timeout_q;
        rd_data_out = ddr.rd_burst_data;
    end

    // Client strobes: only the granted source, only while the burst is outstanding.
    always_comb begin
        p0_wr_data_req   = in_wait & grant_q[SRC_P0_WR] & ddr.wr_burst_data_req;
        p0_wr_finish     = in_wait & grant_q[SRC_P0_WR] & ddr.wr_burst_finish;
        p1_wr_data_req   = in_wait & grant_q[SRC_P1_WR] & ddr.wr_burst_data_req;
        p1_wr_finish     = in_wait & grant_q[SRC_P1_WR] & ddr.wr_burst_finish;
        p0_rd_data_valid = in_wait & grant_q[SRC_P0_RD] & ddr.rd_burst_data_valid;
        p0_rd_finish     = in_wait & grant_q[SRC_P0_RD] & ddr.rd_burst_finish;
        p1_rd_data_valid = in_wait & grant_q[SRC_P1_RD] & ddr.rd_burst_data_valid;
        p1_rd_finish     = in_wait & grant_q[SRC_P1_RD] & ddr.rd_burst_finish;
    end

endmodule
